shader_mem_responder: RTL and testbench
=======================================

// Module: shader_mem_responder
// PURPOSE
//  Memory-side responder for the shader core's simplified memory port.
//  Accepts single-beat 128-bit read/write strobes, stores 128-bit words in a local SRAM array,
//  and returns read data with a fixed, parameterised latency and a valid strobe.
//  Zero-fills the array after reset, flags illegal requests, and sits between shader_core and the top level.
// PARAMETERS
//  DEPTH_WORDS  256           number of 128-bit words; power of 2, 16..4096
//  DATA_WIDTH   128           word width; fixed at 128 (4 x 32-bit lanes)
//  RD_LATENCY   2             accept-to-mem_rd_valid cycles; 1..4
//  BASE_ADDR    32'h0000_0000 byte address of word 0; 16-byte aligned
// PORTS
//  clk            in   1    single clock, rising edge
//  rst            in   1    asynchronous, active-high reset
//  mem_addr       in   32   byte address of request
//  mem_wr_data    in   128  write data
//  mem_wr_enable  in   1    write request strobe, one cycle per request
//  mem_rd_enable  in   1    read request strobe, one cycle per request
//  mem_rd_data    out  128  read data; valid only with mem_rd_valid, else 0
//  mem_rd_valid   out  1    one-cycle pulse per accepted read
//  mem_busy       out  1    1 = requests not accepted (initialisation)
//  mem_err        out  1    one-cycle pulse on a rejected request
//  err_code       out  2    qualified by mem_err: 00 busy, 01 misaligned, 10 out of range, 11 rd+wr both set
//  err_addr       out  32   mem_addr of the most recent rejected request; holds until next error
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=INIT, fill counter=0, all read-pipeline valids cleared.
//   - mem_rd_data=0, mem_rd_valid=0, mem_busy=1, mem_err=0, err_code=0, err_addr=0.
//  FSM INIT:
//   - Writes 0 to word[cnt] each cycle, cnt++.
//   - At cnt==DEPTH_WORDS-1 the write completes and the FSM moves to RUN.
//   - mem_busy is 1 for exactly DEPTH_WORDS cycles after reset release.
//  FSM RUN:
//   - mem_busy=0. There is no other state; only rst returns the FSM to INIT.
//  Address decode:
//   - off = mem_addr - BASE_ADDR (32-bit wrap); idx = off[31:4].
//   - misaligned if off[3:0]!=0; out of range if idx >= DEPTH_WORDS (includes mem_addr < BASE_ADDR via wrap).
//  Request checks (same clk edge; priority busy > rd+wr > misaligned > range):
//   - Any strobe while mem_busy -> dropped, mem_err pulse, code 00.
//   - rd and wr both 1 -> neither performed, code 11.
//   - Rejected request: no array access, no mem_rd_valid; mem_err and err_code appear the next cycle.
//  Write:
//   - Accepted write updates word[idx] at that edge.
//   - A read accepted on the next cycle returns the new data.
//  Read:
//   - Array is sampled at the accept edge into stage 1, then shifts through RD_LATENCY-1 further stages.
//   - mem_rd_valid is high exactly RD_LATENCY cycles after the accept cycle; reads are never reordered.
//   - Snapshot semantics: a write accepted after a read returns that read's older data.
//   - Back-to-back reads every cycle are supported: full throughput, one result per cycle.
//  Reset mid-operation:
//   - In-flight reads are discarded with no valid pulse.
//   - The array is re-zeroed by INIT; the error registers clear.
//  Arithmetic:
//   - Fill counter is $clog2(DEPTH_WORDS) bits wide.
//   - Address compare uses the full 28-bit idx; no silent aliasing of high bits.
// TESTING
//  1 Release rst, poll mem_busy -> low after exactly DEPTH_WORDS cycles; reads of idx 0, 17, DEPTH-1 return 0.
//  2 Write 0xDEADBEEF_01234567_89ABCDEF_CAFEF00D @BASE+0x40, read @BASE+0x40 next cycle
//    -> same word, mem_rd_valid exactly RD_LATENCY cycles after the read strobe.
//  3 Reads @0x00,0x10,0x20,0x30 on 4 consecutive cycles, preloaded with 1..4
//    -> 4 consecutive valid pulses returning 1,2,3,4 in order.
//  4 Read @0x10 then write 0x55.. @0x10 next cycle -> read returns old value; subsequent read returns 0x55...
//  5 Errors:
//    - addr 0x14 -> mem_err, code 01, err_addr=0x14.
//    - addr BASE+DEPTH*16 -> code 10.
//    - rd+wr together -> code 11, memory unchanged.
//    - strobe during INIT -> code 00.
//    - No error case produces mem_rd_valid.
//  6 Assert rst with 2 reads in flight -> no mem_rd_valid pulse;
//    mem_busy high for DEPTH_WORDS cycles; previously written word reads back 0.

Source files
------------

// File: rtl/shader_mem_responder.sv
// Shader-core memory responder: 128-bit word SRAM with zero-fill after reset,
// request checking, and a fixed-latency read pipeline split into 32-bit lanes.

module shader_mem_lane #(
   parameter int DEPTH  = 256,
   parameter int AW     = 8,
   parameter int LANE_W = 32,
   parameter int STAGES = 1
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_idx,
   input  logic [LANE_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_idx,
   output logic [LANE_W-1:0] rd_data
);
   logic [LANE_W-1:0] mem   [DEPTH];
   logic [LANE_W-1:0] dpipe [STAGES+1];

   // Data stages carry no reset; the shared valid pipe masks stale contents.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
      if (rd_en) dpipe[0] <= mem[rd_idx];
      for (int i = 1; i <= STAGES; i++) dpipe[i] <= dpipe[i-1];
   end

   assign rd_data = dpipe[STAGES];
endmodule

module shader_mem_responder #(
   parameter int          DEPTH_WORDS = 256,
   parameter int          DATA_WIDTH  = 128,
   parameter int          RD_LATENCY  = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic                  mem_wr_enable,
   input  logic                  mem_rd_enable,
   output logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  mem_rd_valid,
   output logic                  mem_busy,
   output logic                  mem_err,
   output logic [1:0]            err_code,
   output logic [31:0]           err_addr
);
   localparam int AW        = $clog2(DEPTH_WORDS);
   localparam int LANE_W    = 32;
   localparam int NUM_LANES = DATA_WIDTH / LANE_W;
   localparam int STAGES    = RD_LATENCY - 1;

   typedef enum logic {S_INIT, S_RUN} state_t;
   state_t state, state_nxt;
   logic [AW-1:0] cnt;
   logic          init_we;

   logic [31:0] off;
   logic [27:0] idx;
   logic        any_req, e_both, e_mis, e_rng, rej, rd_acc, wr_acc;
   logic [1:0]  code;

   logic [STAGES:0]                        vld_pipe;
   logic [NUM_LANES-1:0][LANE_W-1:0]       lane_rd;
   logic                                   arr_we;
   logic [AW-1:0]                          arr_widx;
   logic [NUM_LANES-1:0][LANE_W-1:0]       arr_wdata;

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_INIT;
      else     state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      if (state == S_INIT && cnt == AW'(DEPTH_WORDS - 1)) state_nxt = S_RUN;
   end

   // FSM: outputs
   always_comb begin
      mem_busy = 1'b0;
      init_we  = 1'b0;
      if (state == S_INIT) begin
         mem_busy = 1'b1;
         init_we  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          cnt <= '0;
      else if (init_we) cnt <= cnt + 1'b1;
   end

   // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
   always_comb begin
      off     = mem_addr - BASE_ADDR;
      idx     = off[31:4];
      any_req = mem_rd_enable | mem_wr_enable;
      e_both  = mem_rd_enable & mem_wr_enable;
      e_mis   = off[3:0] != 4'd0;
      e_rng   = idx >= 28'(DEPTH_WORDS);
      rej     = any_req & (mem_busy | e_both | e_mis | e_rng);
      rd_acc  = mem_rd_enable & ~rej;
      wr_acc  = mem_wr_enable & ~rej;
      if (mem_busy)    code = 2'b00;
      else if (e_both) code = 2'b11;
      else if (e_mis)  code = 2'b01;
      else             code = 2'b10;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_err  <= 1'b0;
         err_code <= 2'b00;
         err_addr <= 32'd0;
      end else begin
         mem_err <= rej;
         if (rej) begin
            err_code <= code;
            err_addr <= mem_addr;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_pipe <= '0;
      else begin
         vld_pipe[0] <= rd_acc;
         for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   // The zero-fill shares the single write port; no requests are accepted meanwhile.
   assign arr_we    = init_we | wr_acc;
   assign arr_widx  = init_we ? cnt : idx[AW-1:0];
   assign arr_wdata = init_we ? '0 : mem_wr_data;

   genvar g;
   generate
      for (g = 0; g < NUM_LANES; g++) begin : g_lane
         shader_mem_lane #(
            .DEPTH (DEPTH_WORDS),
            .AW    (AW),
            .LANE_W(LANE_W),
            .STAGES(STAGES)
         ) u_lane (
            .clk    (clk),
            .wr_en  (arr_we),
            .wr_idx (arr_widx),
            .wr_data(arr_wdata[g]),
            .rd_en  (rd_acc),
            .rd_idx (idx[AW-1:0]),
            .rd_data(lane_rd[g])
         );
      end
   endgenerate

   assign mem_rd_valid = vld_pipe[STAGES];
   assign mem_rd_data  = mem_rd_valid ? lane_rd : '0;
endmodule

// File: tb/tb_shader_mem_responder.sv
// Scoreboard bench for shader_mem_responder: reference word model, read queue
// checked on every valid pulse, error-path and reset-recovery checks.

module tb_shader_mem_responder;
   localparam int          DEPTH = 64;
   localparam int          LAT   = 3;
   localparam logic [31:0] BASE  = 32'h0000_1000;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  mem_addr = '0;
   logic [127:0] mem_wr_data = '0;
   logic         mem_wr_enable = 1'b0;
   logic         mem_rd_enable = 1'b0;
   logic [127:0] mem_rd_data;
   logic         mem_rd_valid, mem_busy, mem_err;
   logic [1:0]   err_code;
   logic [31:0]  err_addr;

   shader_mem_responder #(
      .DEPTH_WORDS(DEPTH), .DATA_WIDTH(128), .RD_LATENCY(LAT), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .mem_wr_enable(mem_wr_enable), .mem_rd_enable(mem_rd_enable),
      .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .mem_busy(mem_busy),
      .mem_err(mem_err), .err_code(err_code), .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] data;
      int           stamp;
   } exp_t;

   exp_t         exp_q[$];
   logic [127:0] mdl [DEPTH];
   int           cyc = 0;
   int           n_vec = 0;
   int           n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_rd_valid) begin
            if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("rd_data", mem_rd_data, e.data);
               chk("rd_latency", 128'(cyc - e.stamp), 128'(LAT));
            end
         end else chk("rd_data_idle", mem_rd_data, 0);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [127:0] d);
      mem_rd_enable = rd; mem_wr_enable = wr; mem_addr = a; mem_wr_data = d;
      tick();
      mem_rd_enable = 1'b0; mem_wr_enable = 1'b0;
   endtask

   function automatic int widx(input logic [31:0] a);
      logic [31:0] o;
      o = a - BASE;
      return int'(o[31:4]);
   endfunction

   task automatic do_rd(input logic [31:0] a);
      exp_t e;
      e.data = mdl[widx(a)];
      e.stamp = cyc;
      exp_q.push_back(e);
      do_req(1'b1, 1'b0, a, '0);
   endtask

   task automatic do_wr(input logic [31:0] a, input logic [127:0] d);
      mdl[widx(a)] = d;
      do_req(1'b0, 1'b1, a, d);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
      if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 0);
      tick();
   endtask

   task automatic err_req(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] code);
      do_req(rd, wr, a, 128'hBAD0_BAD0);
      chk("err_pulse", mem_err, 1);
      chk("err_code", err_code, code);
      chk("err_addr", err_addr, a);
      tick();
      chk("err_one_cycle", mem_err, 0);
      chk("err_addr_hold", err_addr, a);
   endtask

   // Hold reset, check reset outputs, release, probe INIT rejection, time busy.
   task automatic reset_and_init();
      int n;
      rst = 1'b1;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      tick(); tick();
      chk("rst_busy", mem_busy, 1);
      chk("rst_valid", mem_rd_valid, 0);
      chk("rst_data", mem_rd_data, 0);
      chk("rst_err", mem_err, 0);
      chk("rst_code", err_code, 0);
      chk("rst_eaddr", err_addr, 0);
      rst = 1'b0;
      do_req(1'b1, 1'b0, BASE, '0);
      chk("init_err", mem_err, 1);
      chk("init_code", err_code, 2'b00);
      chk("init_eaddr", err_addr, BASE);
      n = 1;
      while (mem_busy && n < 10000) begin tick(); n++; end
      chk("busy_cycles", 128'(n), 128'(DEPTH));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_and_init();

      // zero-filled words
      do_rd(BASE + 32'h0);
      do_rd(BASE + 32'd17 * 16);
      do_rd(BASE + 32'(DEPTH - 1) * 16);
      drain();

      // write then read next cycle
      do_wr(BASE + 32'h40, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
      do_rd(BASE + 32'h40);
      drain();

      // back-to-back reads
      for (int i = 0; i < 4; i++) do_wr(BASE + 32'(i) * 16, 128'(i + 1));
      for (int i = 0; i < 4; i++) do_rd(BASE + 32'(i) * 16);
      drain();

      // snapshot: read, then overwrite the same word next cycle
      do_rd(BASE + 32'h10);
      do_wr(BASE + 32'h10, {16{8'h55}});
      do_rd(BASE + 32'h10);
      drain();

      // random writes and reads against the model
      for (int i = 0; i < 12; i++) begin
         logic [31:0] a;
         a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 16;
         if ($urandom_range(0, 1) == 1) do_wr(a, {$urandom, $urandom, $urandom, $urandom});
         else do_rd(a);
      end
      drain();

      // error paths
      err_req(1'b1, 1'b0, 32'h14, 2'b01);
      err_req(1'b1, 1'b0, BASE + 32'(DEPTH) * 16, 2'b10);
      err_req(1'b0, 1'b1, BASE - 32'h10, 2'b10);
      err_req(1'b1, 1'b1, BASE + 32'h40, 2'b11);
      do_rd(BASE + 32'h40);
      drain();

      // reset with two reads in flight
      do_rd(BASE + 32'h40);
      do_rd(BASE + 32'h30);
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("midrst_valid", mem_rd_valid, 0);
      reset_and_init();
      do_rd(BASE + 32'h40);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
